// File: rtl/gcd_stein32.sv
// Binary-GCD (Stein) engine: one operand pair in, gcd out, over valid/ready handshakes.
// A single shared trailing-zero counter performs every normalising shift, one per cycle.
module gcd_stein32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] gcd_o
);

    // state    | meaning
    // IDLE     | waiting for an operand pair
    // SHIFT_K  | K = common power of two of A and B
    // NORM_A   | strip trailing zeros from A
    // NORM_B   | strip trailing zeros from B
    // SUB      | A = min, B = |A-B|; finish when the difference is zero
    // DONE     | result held until the consumer takes it
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_K,
        ST_NORM_A,
        ST_NORM_B,
        ST_SUB,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [5:0]       r_k;
    logic [WIDTH-1:0] r_gcd;
    logic             r_valid;
    logic             r_ready;

    logic [WIDTH-1:0] w_tz_in;
    logic [5:0]       w_tz;
    logic             w_a_ge;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_tz_in = r_b;
        case (r_state)
            ST_SHIFT_K: w_tz_in = r_a | r_b;
            ST_NORM_A:  w_tz_in = r_a;
            default:    w_tz_in = r_b;
        endcase
    end

    // Scan from the top so the lowest set bit wins; all-zero input yields 32.
    always_comb begin
        w_tz = 6'd32;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_tz_in[i]) w_tz = 6'(i);
        end
    end

    assign w_a_ge = (r_a >= r_b);
    assign w_lo   = w_a_ge ? r_b : r_a;
    assign w_diff = w_a_ge ? (r_a - r_b) : (r_b - r_a);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_gcd   <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_i && r_ready) begin
                        r_a     <= a_i;
                        r_b     <= b_i;
                        r_ready <= 1'b0;
                        if (a_i == '0 || b_i == '0) begin
                            r_gcd   <= a_i | b_i;
                            r_valid <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_SHIFT_K;
                        end
                    end
                end
                ST_SHIFT_K: begin
                    r_k     <= w_tz;
                    r_state <= ST_NORM_A;
                end
                ST_NORM_A: begin
                    r_a     <= r_a >> w_tz;
                    r_state <= ST_NORM_B;
                end
                ST_NORM_B: begin
                    r_b     <= r_b >> w_tz;
                    r_state <= ST_SUB;
                end
                ST_SUB: begin
                    r_a <= w_lo;
                    r_b <= w_diff;
                    if (w_diff == '0) begin
                        r_gcd   <= w_lo << r_k;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_NORM_B;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign gcd_o   = r_gcd;

endmodule
